// File: rtl/piq_pkg.sv
// Shared types and constants for the peripheral interrupt taker.
// Vectored trap entry is enabled by defining PIQ_VECTORED_EN.
package piq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    COMMIT  = 2'd2,
    HANDLER = 2'd3
  } piq_state_e;

  localparam int PIQ_XLEN          = 32;
  localparam int MEM_ERR_CAUSE     = 12;
  localparam int PERIPH_CAUSE_BASE = 13;
  localparam int MCAUSE_INT_BIT    = PIQ_XLEN - 1;

endpackage

// File: rtl/peripheral_interrupt_taker_trap_vector_calc.sv
// Combinational trap target from mtvec and cause.
// Define PIQ_VECTORED_EN to honour mtvec mode 2'b01 (base + cause*4); otherwise direct mode only.
module trap_vector_calc
  import piq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] trap_pc
);

  logic [XLEN-1:0] base;
  logic            unused_bits;

  assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef PIQ_VECTORED_EN
  logic [XLEN-1:0] offset;

  // The interrupt flag bit of the cause never contributes to the offset.
  assign offset      = {1'b0, cause[XLEN-2:0]} << 2;
  assign unused_bits = cause[XLEN-1];

  always_comb begin
    trap_pc = base;
    if (mtvec[1:0] == 2'b01) begin
      trap_pc = base + offset;
    end
  end
`else
  assign unused_bits = ^{mtvec[1:0], cause};
  assign trap_pc     = base;
`endif

endmodule

// File: rtl/peripheral_interrupt_taker.sv
// CSR-side taker for the peripheral interrupt queue: qualifies, acknowledges and enters the trap.
// All outputs registered; trap entry two cycles after qualifying conditions. PIQ_VECTORED_EN selects vectored mtvec.
module peripheral_interrupt_taker
  import piq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RETRIES_MAX = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_int,
  input  logic [XLEN-1:0] p_mcause,
  output logic            p_int_read,
  output logic            csr_busy,
  input  logic            csr_instr_busy,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] epc,
  input  logic            epc_valid,
  input  logic            mret,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_pc,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_wdata,
  output logic            mstatus_trap,
  output logic            in_handler,
  output logic            trap_starve
);

  localparam int              CW        = (RETRIES_MAX < 2) ? 1 : $clog2(RETRIES_MAX + 1);
  localparam logic [CW-1:0]   RETRY_SAT = CW'(RETRIES_MAX);
  localparam logic [CW-1:0]   RETRY_ONE = CW'(1);

  piq_state_e      state_q, state_d;
  logic [CW-1:0]   retry_q, retry_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            starve_d;
  logic            take_ok;
  logic            commit_d;
  logic [XLEN-1:0] vec_pc;

  logic            ack_q, ack_d;
  logic            csr_busy_q, csr_busy_d;
  logic            in_handler_q, in_handler_d;
  logic            starve_q;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [XLEN-1:0] mepc_wdata_q, mepc_wdata_d;
  logic [XLEN-1:0] mcause_wdata_q, mcause_wdata_d;

  assign take_ok = p_int & mstatus_mie & ~csr_instr_busy;

  trap_vector_calc #(.XLEN(XLEN)) u_vec (
    .mtvec   (mtvec),
    .cause   (cause_d),
    .trap_pc (vec_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      retry_q        <= '0;
      cause_q        <= '0;
      epc_q          <= '0;
      ack_q          <= 1'b0;
      csr_busy_q     <= 1'b0;
      in_handler_q   <= 1'b0;
      starve_q       <= 1'b0;
      trap_pc_q      <= '0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      cause_q        <= cause_d;
      epc_q          <= epc_d;
      ack_q          <= ack_d;
      csr_busy_q     <= csr_busy_d;
      in_handler_q   <= in_handler_d;
      starve_q       <= starve_d;
      trap_pc_q      <= trap_pc_d;
      mepc_wdata_q   <= mepc_wdata_d;
      mcause_wdata_q <= mcause_wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    starve_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_ok) state_d = QUAL;
      end
      QUAL: begin
        if (take_ok && epc_valid) begin
          state_d = COMMIT;
          cause_d = p_mcause;
          epc_d   = epc;
        end else begin
          state_d = IDLE;
          if (retry_q != RETRY_SAT) begin
            retry_d  = retry_q + RETRY_ONE;
            // Fires only on the abort that reaches saturation, so one pulse per starvation run.
            starve_d = (retry_q + RETRY_ONE == RETRY_SAT);
          end
        end
      end
      COMMIT: begin
        state_d = HANDLER;
        retry_d = '0;
      end
      HANDLER: begin
        // No nesting: a presented interrupt waits here until mret regardless of MIE.
        if (mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state once registered.
  always_comb begin
    commit_d       = (state_d == COMMIT);
    ack_d          = commit_d;
    csr_busy_d     = commit_d ? 1'b0 : csr_instr_busy;
    in_handler_d   = (state_d == HANDLER);
    trap_pc_d      = commit_d ? vec_pc : '0;
    mepc_wdata_d   = commit_d ? (epc_d & ~XLEN'(3)) : '0;
    mcause_wdata_d = commit_d ? {1'b1, cause_d[XLEN-2:0]} : '0;
  end

  assign p_int_read   = ack_q;
  assign trap_taken   = ack_q;
  assign mepc_we      = ack_q;
  assign mcause_we    = ack_q;
  assign mstatus_trap = ack_q;
  assign csr_busy     = csr_busy_q;
  assign in_handler   = in_handler_q;
  assign trap_starve  = starve_q;
  assign trap_pc      = trap_pc_q;
  assign mepc_wdata   = mepc_wdata_q;
  assign mcause_wdata = mcause_wdata_q;

endmodule
